// File: rtl/zpu_small_cpu.sv
// ZPU "small" stack CPU: one instruction fetched per word access, stack kept in memory,
// single outstanding request/done memory port, interrupt entry, EMULATE and BREAKPOINT.
module zpu_small_cpu #(
    parameter logic [31:0] STACK_TOP  = 32'h003F_FFF8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_interrupt,
    output logic        o_read,
    output logic        o_write,
    input  logic        i_done,
    output logic [31:0] o_addr,
    input  logic [31:0] i_data_read,
    output logic [31:0] o_data_write
);

    localparam int unsigned W = 32;

    typedef enum logic [3:0] {
        S_FETCH, S_FETCH_WT, S_DECODE, S_RD1_WT, S_EXEC1,
        S_RD2_WT, S_EXEC2, S_WR_WT, S_HALT
    } state_e;

    typedef enum logic [4:0] {
        OP_IM, OP_STORESP, OP_LOADSP, OP_ADDSP, OP_EMULATE, OP_BREAK,
        OP_PUSHSP, OP_POPPC, OP_ADD, OP_AND, OP_OR, OP_LOAD, OP_NOT,
        OP_FLIP, OP_STORE, OP_POPSP, OP_NOP
    } op_e;

    state_e         state_q, state_d;
    op_e            op_c;
    logic [W-1:0]   pc_q, pc_d, sp_q, sp_d, a_q, a_d, b_q, b_d, tmp_q, tmp_d;
    logic [W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]     opcode_q, opcode_d;
    logic           idim_q, idim_d, int_active_q, int_active_d, halted_q, halted_d;
    logic           rd_q, rd_d, wr_q, wr_d;
    logic           take_int_c;
    logic [W-1:0]   sp_m4_c, sp_p4_c, spoff_c, addoff_c;

    function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    assign o_read       = rd_q;
    assign o_write      = wr_q;
    assign o_addr       = addr_q;
    assign o_data_write = wdata_q;

    assign take_int_c = i_interrupt & ~int_active_q & ~idim_q & ~halted_q;
    assign sp_m4_c    = sp_q - W'(4);
    assign sp_p4_c    = sp_q + W'(4);
    assign spoff_c    = {25'd0, opcode_q[4:0] ^ 5'h10, 2'b00};
    assign addoff_c   = {26'd0, opcode_q[3:0], 2'b00};

    // Opcode class of the latched instruction byte
    always_comb begin
        op_c = OP_NOP;
        if (opcode_q[7])                    op_c = OP_IM;
        else if (opcode_q[7:5] == 3'b010)   op_c = OP_STORESP;
        else if (opcode_q[7:5] == 3'b011)   op_c = OP_LOADSP;
        else if (opcode_q[7:4] == 4'b0001)  op_c = OP_ADDSP;
        else if (opcode_q[7:5] == 3'b001)   op_c = OP_EMULATE;
        else begin
            case (opcode_q[3:0])
                4'h0:    op_c = OP_BREAK;
                4'h2:    op_c = OP_PUSHSP;
                4'h4:    op_c = OP_POPPC;
                4'h5:    op_c = OP_ADD;
                4'h6:    op_c = OP_AND;
                4'h7:    op_c = OP_OR;
                4'h8:    op_c = OP_LOAD;
                4'h9:    op_c = OP_NOT;
                4'hA:    op_c = OP_FLIP;
                4'hC:    op_c = OP_STORE;
                4'hD:    op_c = OP_POPSP;
                default: op_c = OP_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = take_int_c ? S_WR_WT : S_FETCH_WT;
            S_FETCH_WT: if (i_done) state_d = S_DECODE;
            S_DECODE: begin
                case (op_c)
                    OP_IM:                 state_d = idim_q ? S_RD1_WT : S_WR_WT;
                    OP_EMULATE, OP_PUSHSP: state_d = S_WR_WT;
                    OP_BREAK:              state_d = S_HALT;
                    OP_NOP:                state_d = S_FETCH;
                    default:               state_d = S_RD1_WT;
                endcase
            end
            S_RD1_WT:   if (i_done) state_d = S_EXEC1;
            S_EXEC1: begin
                case (op_c)
                    OP_ADDSP, OP_ADD, OP_AND, OP_OR, OP_LOAD, OP_STORE: state_d = S_RD2_WT;
                    OP_POPPC, OP_POPSP:                                 state_d = S_FETCH;
                    default:                                            state_d = S_WR_WT;
                endcase
            end
            S_RD2_WT:   if (i_done) state_d = S_EXEC2;
            S_EXEC2:    state_d = S_WR_WT;
            S_WR_WT:    if (i_done) state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Datapath and bus request sequencing; requests are issued on entry to a *_WT state
    always_comb begin
        pc_d = pc_q;   sp_d = sp_q;   a_d = a_q;   b_d = b_q;   tmp_d = tmp_q;
        opcode_d = opcode_q;   idim_d = idim_q;   int_active_d = int_active_q;
        halted_d = halted_q;   rd_d = rd_q;   wr_d = wr_q;
        addr_d = addr_q;   wdata_d = wdata_q;
        case (state_q)
            S_FETCH: begin
                if (take_int_c) begin
                    sp_d = sp_m4_c;  wr_d = 1'b1;  addr_d = sp_m4_c;  wdata_d = pc_q;
                    pc_d = INT_VECTOR;  int_active_d = 1'b1;  idim_d = 1'b0;
                end else begin
                    rd_d = 1'b1;  addr_d = {pc_q[31:2], 2'b00};
                end
            end
            S_FETCH_WT: begin
                if (i_done) begin
                    rd_d = 1'b0;
                    case (pc_q[1:0])
                        2'd0:    opcode_d = i_data_read[31:24];
                        2'd1:    opcode_d = i_data_read[23:16];
                        2'd2:    opcode_d = i_data_read[15:8];
                        default: opcode_d = i_data_read[7:0];
                    endcase
                end
            end
            S_DECODE: begin
                pc_d   = pc_q + W'(1);
                idim_d = (op_c == OP_IM);
                case (op_c)
                    OP_IM: begin
                        if (idim_q) begin
                            rd_d = 1'b1;  addr_d = sp_q;
                        end else begin
                            sp_d = sp_m4_c;  wr_d = 1'b1;  addr_d = sp_m4_c;
                            wdata_d = {{25{opcode_q[6]}}, opcode_q[6:0]};
                        end
                    end
                    OP_STORESP: begin
                        tmp_d = sp_q + spoff_c;  rd_d = 1'b1;  addr_d = sp_q;  sp_d = sp_p4_c;
                    end
                    OP_LOADSP: begin rd_d = 1'b1;  addr_d = sp_q + spoff_c; end
                    OP_ADDSP:  begin rd_d = 1'b1;  addr_d = sp_q + addoff_c; end
                    OP_EMULATE: begin
                        sp_d = sp_m4_c;  wr_d = 1'b1;  addr_d = sp_m4_c;  wdata_d = pc_q + W'(1);
                        pc_d = {22'd0, opcode_q[4:0], 5'd0};
                    end
                    OP_BREAK:  halted_d = 1'b1;
                    OP_PUSHSP: begin
                        sp_d = sp_m4_c;  wr_d = 1'b1;  addr_d = sp_m4_c;  wdata_d = sp_q;
                    end
                    OP_NOP:    ;
                    default:   begin rd_d = 1'b1;  addr_d = sp_q; end
                endcase
            end
            S_RD1_WT: if (i_done) begin rd_d = 1'b0;  a_d = i_data_read; end
            S_EXEC1: begin
                case (op_c)
                    OP_IM:      begin wr_d = 1'b1;  addr_d = sp_q;  wdata_d = {a_q[24:0], opcode_q[6:0]}; end
                    OP_STORESP: begin wr_d = 1'b1;  addr_d = tmp_q;  wdata_d = a_q; end
                    OP_LOADSP:  begin sp_d = sp_m4_c;  wr_d = 1'b1;  addr_d = sp_m4_c;  wdata_d = a_q; end
                    OP_ADDSP:   begin rd_d = 1'b1;  addr_d = sp_q; end
                    OP_POPPC:   begin pc_d = a_q;  sp_d = sp_p4_c;  int_active_d = 1'b0; end
                    OP_ADD, OP_AND, OP_OR, OP_STORE: begin rd_d = 1'b1;  addr_d = sp_p4_c; end
                    OP_LOAD:    begin rd_d = 1'b1;  addr_d = {a_q[31:2], 2'b00}; end
                    OP_NOT:     begin wr_d = 1'b1;  addr_d = sp_q;  wdata_d = ~a_q; end
                    OP_FLIP:    begin wr_d = 1'b1;  addr_d = sp_q;  wdata_d = bit_rev(a_q); end
                    OP_POPSP:   sp_d = a_q;
                    default:    ;
                endcase
            end
            S_RD2_WT: if (i_done) begin rd_d = 1'b0;  b_d = i_data_read; end
            S_EXEC2: begin
                case (op_c)
                    OP_ADDSP: begin wr_d = 1'b1;  addr_d = sp_q;  wdata_d = a_q + b_q; end
                    OP_ADD:   begin sp_d = sp_p4_c;  wr_d = 1'b1;  addr_d = sp_p4_c;  wdata_d = a_q + b_q; end
                    OP_AND:   begin sp_d = sp_p4_c;  wr_d = 1'b1;  addr_d = sp_p4_c;  wdata_d = a_q & b_q; end
                    OP_OR:    begin sp_d = sp_p4_c;  wr_d = 1'b1;  addr_d = sp_p4_c;  wdata_d = a_q | b_q; end
                    OP_LOAD:  begin wr_d = 1'b1;  addr_d = sp_q;  wdata_d = b_q; end
                    OP_STORE: begin
                        sp_d = sp_q + W'(8);  wr_d = 1'b1;  addr_d = {a_q[31:2], 2'b00};  wdata_d = b_q;
                    end
                    default:  ;
                endcase
            end
            S_WR_WT: if (i_done) wr_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;   sp_q <= STACK_TOP;   a_q <= '0;   b_q <= '0;   tmp_q <= '0;
            opcode_q <= '0;   idim_q <= 1'b0;   int_active_q <= 1'b0;   halted_q <= 1'b0;
            rd_q <= 1'b0;   wr_q <= 1'b0;   addr_q <= '0;   wdata_q <= '0;
        end else begin
            pc_q <= pc_d;   sp_q <= sp_d;   a_q <= a_d;   b_q <= b_d;   tmp_q <= tmp_d;
            opcode_q <= opcode_d;   idim_q <= idim_d;   int_active_q <= int_active_d;
            halted_q <= halted_d;   rd_q <= rd_d;   wr_q <= wr_d;
            addr_q <= addr_d;   wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_zpu_small_cpu.sv
// Bench for zpu_small_cpu: word-RAM responder with programmable latency and a write scoreboard.
module tb_zpu_small_cpu;

    logic        clk, reset, i_interrupt, o_read, o_write, i_done;
    logic [31:0] o_addr, i_data_read, o_data_write;

    zpu_small_cpu dut (
        .clk(clk), .reset(reset), .i_interrupt(i_interrupt),
        .o_read(o_read), .o_write(o_write), .i_done(i_done),
        .o_addr(o_addr), .i_data_read(i_data_read), .o_data_write(o_data_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic wr; logic [31:0] addr; } acc_t;

    logic [31:0] pmem [logic [31:0]];
    logic [31:0] wmem [logic [31:0]];
    logic [63:0] exp_q [$];
    acc_t        log_q [$];
    int          n_vec = 0, n_err = 0;
    int          lat = 0;
    int          extra_wr, int_wr_cnt;
    bit          int_mode = 1'b0, int_raised;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        if (pmem.exists(a)) return pmem[a];
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Memory responder: answers after lat wait cycles, checks request stability and scoreboards writes
    initial begin
        int          wcnt;
        bit          busy;
        logic [31:0] cap_addr, cap_data;
        logic        cap_wr;
        logic [63:0] e;
        i_done = 1'b0; i_data_read = '0; i_interrupt = 1'b0;
        wcnt = 0; busy = 1'b0; extra_wr = 0; int_wr_cnt = 0; int_raised = 1'b0;
        cap_addr = '0; cap_data = '0; cap_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                i_done = 1'b0; busy = 1'b0; wcnt = 0; i_interrupt = 1'b0;
                extra_wr = 0; int_wr_cnt = 0; int_raised = 1'b0;
                wmem.delete(); log_q.delete();
            end else if (i_done) begin
                i_done = 1'b0; busy = 1'b0;
            end else if (o_read || o_write) begin
                if (!busy) begin
                    busy = 1'b1; wcnt = 0;
                    cap_addr = o_addr; cap_data = o_data_write; cap_wr = o_write;
                end else begin
                    chk("addr_stable", o_addr, cap_addr);
                    chk("dir_stable", 32'(o_write), 32'(cap_wr));
                    if (cap_wr) chk("wdata_stable", o_data_write, cap_data);
                end
                if (wcnt >= lat) begin
                    chk("rw_excl", 32'(o_read & o_write), 32'd0);
                    log_q.push_back({o_write, o_addr});
                    if (o_write) begin
                        wmem[o_addr] = o_data_write;
                        if (exp_q.size() == 0) extra_wr++;
                        else begin
                            e = exp_q.pop_front();
                            chk("wr_addr", o_addr, e[63:32]);
                            chk("wr_data", o_data_write, e[31:0]);
                        end
                        if (int_mode) begin
                            int_wr_cnt++;
                            if (int_wr_cnt == 4) i_interrupt = 1'b0;
                        end
                    end else begin
                        i_data_read = rd_mem(o_addr);
                        if (int_mode && !int_raised && o_addr == 32'h4) begin
                            i_interrupt = 1'b1; int_raised = 1'b1;
                        end
                    end
                    i_done = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic begin_test(input int l);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_read", 32'(o_read), 32'd0);
        chk("rst_write", 32'(o_write), 32'd0);
        chk("rst_addr", o_addr, 32'd0);
        chk("rst_wdata", o_data_write, 32'd0);
        pmem.delete(); exp_q.delete();
        lat = l;
    endtask

    task automatic go();
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_prog(input string name, input int budget);
        int cyc, busy_cnt;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i >= 40 && (o_read || o_write)) busy_cnt++;
        end
        chk({name, "_halt_quiet"}, 32'(busy_cnt), 32'd0);
        chk({name, "_extra_wr"}, 32'(extra_wr), 32'd0);
    endtask

    function automatic int first_wr();
        foreach (log_q[i]) if (log_q[i].wr) return i;
        return -1;
    endfunction

    initial begin
        int idx, cyc;
        reset = 1'b0;

        // NOP x3 then BREAKPOINT
        begin_test(0);
        pmem[32'h0] = 32'h0B0B_0B00;
        go();
        run_prog("nop_brk", 2000);
        chk("nop_brk_nacc", 32'(log_q.size()), 32'd4);
        foreach (log_q[i]) begin
            chk("nop_brk_faddr", log_q[i].addr, 32'h0);
            chk("nop_brk_fread", 32'(log_q[i].wr), 32'd0);
        end

        // IM -1; NOP; IM 5; IM 3 (continuation)
        begin_test(0);
        pmem[32'h0] = 32'hFF0B_8583; pmem[32'h4] = 32'h0;
        exp_wr(32'h003F_FFF4, 32'hFFFF_FFFF);
        exp_wr(32'h003F_FFF0, 32'h0000_0005);
        exp_wr(32'h003F_FFF0, 32'h0000_0283);
        go();
        run_prog("im", 2000);

        // 3+4 stored to 0x40, then PUSHSP shows SP back at STACK_TOP; zero-wait and 5-wait
        for (int pass = 0; pass < 2; pass++) begin
            begin_test(pass * 5);
            pmem[32'h0] = 32'h830B_8405; pmem[32'h4] = 32'h80C0_0C02; pmem[32'h8] = 32'h0;
            exp_wr(32'h003F_FFF4, 32'd3);
            exp_wr(32'h003F_FFF0, 32'd4);
            exp_wr(32'h003F_FFF4, 32'd7);
            exp_wr(32'h003F_FFF0, 32'd0);
            exp_wr(32'h003F_FFF0, 32'h40);
            exp_wr(32'h0000_0040, 32'd7);
            exp_wr(32'h003F_FFF4, 32'h003F_FFF8);
            go();
            run_prog(pass == 0 ? "store_w0" : "store_w5", 4000);
            chk("store_mem40", rd_mem(32'h40), 32'd7);
        end

        // OR, NOT, FLIP, LOADSP, ADDSP, AND, STORESP, LOAD, PUSHSP/POPSP
        begin_test(1);
        pmem[32'h0] = 32'h850B_8C07; pmem[32'h4] = 32'h090A_7011;
        pmem[32'h8] = 32'h8306_5108; pmem[32'hC] = 32'h020D_0200;
        exp_wr(32'h003F_FFF4, 32'h0000_0005);
        exp_wr(32'h003F_FFF0, 32'h0000_000C);
        exp_wr(32'h003F_FFF4, 32'h0000_000D);
        exp_wr(32'h003F_FFF4, 32'hFFFF_FFF2);
        exp_wr(32'h003F_FFF4, 32'h4FFF_FFFF);
        exp_wr(32'h003F_FFF0, 32'h4FFF_FFFF);
        exp_wr(32'h003F_FFF0, 32'h9FFF_FFFE);
        exp_wr(32'h003F_FFEC, 32'h0000_0003);
        exp_wr(32'h003F_FFF0, 32'h0000_0002);
        exp_wr(32'h003F_FFF4, 32'h0000_0002);
        exp_wr(32'h003F_FFF4, 32'h850B_8C07);
        exp_wr(32'h003F_FFF0, 32'h003F_FFF4);
        exp_wr(32'h003F_FFF0, 32'h003F_FFF4);
        go();
        run_prog("alu", 4000);

        // EMULATE 5 at PC 0x10
        begin_test(2);
        for (int i = 0; i < 4; i++) pmem[32'(i * 4)] = 32'h0B0B_0B0B;
        pmem[32'h10] = 32'h2500_0000; pmem[32'hA0] = 32'h0200_0000;
        exp_wr(32'h003F_FFF4, 32'h0000_0011);
        exp_wr(32'h003F_FFF0, 32'h003F_FFF4);
        go();
        run_prog("emu", 4000);
        idx = first_wr();
        chk("emu_wr_found", 32'(idx >= 0), 32'd1);
        if (idx >= 0 && idx + 1 < log_q.size()) begin
            chk("emu_next_fetch", log_q[idx+1].addr, 32'h0000_00A0);
            chk("emu_next_is_rd", 32'(log_q[idx+1].wr), 32'd0);
        end else chk("emu_log_len", 32'(log_q.size()), 32'(idx + 2));

        // Interrupt held across the handler: re-entry only after POPPC
        begin_test(0);
        int_mode = 1'b1;
        pmem[32'h0] = 32'h0B0B_0B0B; pmem[32'h4] = 32'h0B0B_0B00;
        pmem[32'h20] = 32'h020D_0400;
        exp_wr(32'h003F_FFF4, 32'h0000_0005);
        exp_wr(32'h003F_FFF0, 32'h003F_FFF4);
        exp_wr(32'h003F_FFF4, 32'h0000_0005);
        exp_wr(32'h003F_FFF0, 32'h003F_FFF4);
        go();
        run_prog("irq", 4000);
        int_mode = 1'b0;
        idx = first_wr();
        chk("irq_wr_found", 32'(idx >= 0), 32'd1);
        if (idx >= 0 && idx + 1 < log_q.size())
            chk("irq_vector_fetch", log_q[idx+1].addr, 32'h0000_0020);
        else chk("irq_log_len", 32'(log_q.size()), 32'(idx + 2));
        if (log_q.size() > 0) chk("irq_return_fetch", log_q[log_q.size()-1].addr, 32'h4);

        // Reset asserted while a read is outstanding drops the request at once
        begin_test(5);
        pmem[32'h0] = 32'h0B0B_0B00;
        go();
        cyc = 0;
        while (!o_read && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_req_seen", 32'(o_read), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_read", 32'(o_read), 32'd0);
        chk("midrst_write", 32'(o_write), 32'd0);
        chk("midrst_addr", o_addr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
